dbg_seg_router: RTL and testbench

- Single-master debug transaction controller between the host-side debug port (PYNQ/AXI bridge) and the four debug segments: CTL, ROM, RAM and IO.
- Accepts one 14-bit-addressed byte transaction at a time and decodes segment (addr[13:12]) and offset (addr[11:0]).
- Rejects illegal offsets locally. Otherwise issues a req/ack handshake to the selected segment target, with timeout.
- Returns a single response (rdata, err) to the host.

---
 rtl/dbg_seg_router.sv | 166 ++++++++++++++++
 tb/tb_dbg_seg_router.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dbg_seg_router.sv
// dbg_seg_router: single-master debug transaction controller.
// Decodes a 14-bit host address into segment/offset, rejects illegal
// offsets locally, runs a req/ack handshake with the selected segment
// target (with timeout) and returns one response to the host.
module dbg_seg_router #(
  parameter int Timeout_cycles = 256,
  parameter int Data_width     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_req_valid,
  output logic                    host_req_ready,
  input  logic                    host_req_write,
  input  logic [13:0]             host_req_addr,
  input  logic [Data_width-1:0]   host_req_wdata,
  output logic                    host_rsp_valid,
  input  logic                    host_rsp_ready,
  output logic [Data_width-1:0]   host_rsp_rdata,
  output logic                    host_rsp_err,
  output logic [3:0]              tgt_req,
  output logic                    tgt_write,
  output logic [11:0]             tgt_addr,
  output logic [Data_width-1:0]   tgt_wdata,
  input  logic [3:0]              tgt_ack,
  input  logic [4*Data_width-1:0] tgt_rdata
);

  localparam int CW = $clog2(Timeout_cycles + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(Timeout_cycles - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(Timeout_cycles);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [3:0]            req_reg, req_next;
  logic [1:0]            seg_reg, seg_next;
  logic                  write_reg, write_next;
  logic [11:0]           addr_reg, addr_next;
  logic [Data_width-1:0] wdata_reg, wdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [Data_width-1:0] rdata_reg, rdata_next;
  logic                  err_reg, err_next;

  // Per-segment read data split into lanes so the selected one can be indexed by segment.
  logic [Data_width-1:0] lane_rdata [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_rdata[gi] = tgt_rdata[gi*Data_width +: Data_width];
    end
  endgenerate

  // Offset legality per segment; CTL debug registers at 0x004..0x006 are read-only.
  function automatic logic offset_legal(input logic [1:0] seg, input logic [11:0] off,
                                        input logic wr);
    logic legal;
    legal = 1'b0;
    case (seg)
      2'd0: legal = (off == 12'h000) ||
                    (off >= 12'h004 && off <= 12'h006 && !wr) ||
                    (off >= 12'h008 && off <= 12'h00F);
      2'd1, 2'd2: legal = 1'b1;
      default: legal = ((off & 12'hFF8) == 12'h000) || ((off & 12'hFF8) == 12'h010);
    endcase
    return legal;
  endfunction

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_reg       <= '0;
      seg_reg       <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_reg       <= req_next;
      seg_reg       <= seg_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic: accept/decode in IDLE, handshake with timeout in ISSUE, hold response in RESP.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_next       = req_reg;
    seg_next       = seg_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (host_req_valid) begin
          seg_next   = host_req_addr[13:12];
          write_next = host_req_write;
          addr_next  = host_req_addr[11:0];
          wdata_next = host_req_wdata;
          cnt_next   = '0;
          if (offset_legal(host_req_addr[13:12], host_req_addr[11:0], host_req_write)) begin
            req_next   = 4'b0001 << host_req_addr[13:12];
            state_next = ISSUE;
          end else begin
            rsp_valid_next = 1'b1;
            err_next       = 1'b1;
            rdata_next     = '0;
            state_next     = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
        // A matching ack takes priority over a timeout landing in the same cycle.
        if (tgt_ack[seg_reg]) begin
          req_next       = '0;
          rsp_valid_next = 1'b1;
          err_next       = 1'b0;
          rdata_next     = write_reg ? '0 : lane_rdata[seg_reg];
          state_next     = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          req_next       = '0;
          rsp_valid_next = 1'b1;
          err_next       = 1'b1;
          rdata_next     = '1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (host_rsp_ready) begin
          rsp_valid_next = 1'b0;
          rdata_next     = '0;
          err_next       = 1'b0;
          cnt_next       = '0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign host_req_ready = (state_reg == IDLE) && !rst;
  assign host_rsp_valid = rsp_valid_reg;
  assign host_rsp_rdata = rdata_reg;
  assign host_rsp_err   = err_reg;
  assign tgt_req        = req_reg;
  assign tgt_write      = write_reg;
  assign tgt_addr       = addr_reg;
  assign tgt_wdata      = wdata_reg;

endmodule

// File: tb/tb_dbg_seg_router.sv
// Directed table-driven bench for dbg_seg_router, plus a reset-in-flight sequence.
module tb_dbg_seg_router;

  localparam int T = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req_valid, host_req_ready, host_req_write;
  logic [13:0] host_req_addr;
  logic [7:0]  host_req_wdata;
  logic        host_rsp_valid, host_rsp_ready, host_rsp_err;
  logic [7:0]  host_rsp_rdata;
  logic [3:0]  tgt_req;
  logic        tgt_write;
  logic [11:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [3:0]  tgt_ack;
  logic [31:0] tgt_rdata;

  int tests = 0;
  int fails = 0;

  dbg_seg_router #(.Timeout_cycles(T), .Data_width(8)) dut (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_write(host_req_write), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
    .tgt_req(tgt_req), .tgt_write(tgt_write), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
    int          ack_at;   // req cycle (0-based) in which the lane ack is driven; -1 = never
    logic [3:0]  spur;     // acks driven on other lanes throughout
    int          hold;     // cycles host_rsp_ready is held low after the response appears
    logic [3:0]  exp_req;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    int          exp_lat;  // cycles from the cycle after accept until host_rsp_valid
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int  lat;
    int  req_cyc;
    bit  done;
    bit  req_seen;
    logic [7:0] r_hold;
    logic       e_hold;
    done = 1'b0; req_seen = 1'b0; req_cyc = 0; lat = 0;
    @(posedge clk); #1;
    host_req_valid = 1'b1; host_req_write = v.wr;
    host_req_addr = v.addr; host_req_wdata = v.wdata;
    @(negedge clk);
    chk({v.name, ".ready"}, 32'(host_req_ready), 32'd1);
    @(posedge clk); #1;
    host_req_valid = 1'b0;
    for (int k = 0; k <= T + 20; k++) begin
      @(negedge clk);
      if (host_rsp_valid) begin
        done = 1'b1;
        lat = k;
        break;
      end
      if (tgt_req != 4'b0000) begin
        req_cyc++;
        if (!req_seen) begin
          req_seen = 1'b1;
          chk({v.name, ".tgt_req"}, 32'(tgt_req), 32'(v.exp_req));
          chk({v.name, ".tgt_addr"}, 32'(tgt_addr), 32'(v.addr[11:0]));
          chk({v.name, ".tgt_write"}, 32'(tgt_write), 32'(v.wr));
          chk({v.name, ".tgt_wdata"}, 32'(tgt_wdata), 32'(v.wdata));
        end
      end
      tgt_ack = (k == v.ack_at) ? (v.spur | v.exp_req) : v.spur;
    end
    tgt_ack = 4'b0000;
    if (!done) begin
      chk({v.name, ".rsp_wait"}, 32'd0, 32'd1);
      return;
    end
    chk({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, ".req_cycles"}, 32'(req_cyc), (v.exp_req == 4'b0000) ? 32'd0 : 32'(v.exp_lat));
    chk({v.name, ".req_dropped"}, 32'(tgt_req), 32'd0);
    chk({v.name, ".err"}, 32'(host_rsp_err), 32'(v.exp_err));
    chk({v.name, ".rdata"}, 32'(host_rsp_rdata), 32'(v.exp_rdata));
    r_hold = host_rsp_rdata; e_hold = host_rsp_err;
    $display("[TB] txn %s addr=%04h wr=%0b lat=%0d err=%0b rdata=%02h",
             v.name, v.addr, v.wr, lat, host_rsp_err, host_rsp_rdata);
    for (int h = 0; h < v.hold; h++) begin
      tgt_ack = v.spur | v.exp_req;   // acks outside ISSUE must be ignored
      @(negedge clk);
      chk({v.name, ".hold_valid"}, 32'(host_rsp_valid), 32'd1);
      chk({v.name, ".hold_stable"}, {23'd0, host_rsp_err, host_rsp_rdata}, {23'd0, e_hold, r_hold});
      chk({v.name, ".hold_ready"}, 32'(host_req_ready), 32'd0);
    end
    tgt_ack = 4'b0000;
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    chk({v.name, ".rsp_cleared"}, {22'd0, host_rsp_valid, host_rsp_err, host_rsp_rdata}, 32'd0);
    chk({v.name, ".back_idle"}, 32'(host_req_ready), 32'd1);
  endtask

  initial begin
    // Lane read data: CTL=3C, ROM=A5, RAM=5A, IO=C3.
    vecs[0]  = '{"ram_rd",     1'b0, 14'h2005, 8'h00,  3, 4'b0000, 0, 4'b0100, 1'b0, 8'h5A, 4};
    vecs[1]  = '{"ctl_wr_pc",  1'b1, 14'h0004, 8'h11, -1, 4'b0000, 0, 4'b0000, 1'b1, 8'h00, 0};
    vecs[2]  = '{"ctl_wr_idx", 1'b1, 14'h000A, 8'h03,  0, 4'b0000, 0, 4'b0001, 1'b0, 8'h00, 1};
    vecs[3]  = '{"io_13",      1'b0, 14'h3013, 8'h00,  1, 4'b0000, 0, 4'b1000, 1'b0, 8'hC3, 2};
    vecs[4]  = '{"io_08",      1'b0, 14'h3008, 8'h00, -1, 4'b0000, 0, 4'b0000, 1'b1, 8'h00, 0};
    vecs[5]  = '{"io_20",      1'b0, 14'h3020, 8'h00, -1, 4'b0000, 0, 4'b0000, 1'b1, 8'h00, 0};
    vecs[6]  = '{"rom_tmo",    1'b0, 14'h1123, 8'h00, -1, 4'b0000, 0, 4'b0010, 1'b1, 8'hFF, T};
    vecs[7]  = '{"rom_last",   1'b0, 14'h1ABC, 8'h00, T-1, 4'b0000, 0, 4'b0010, 1'b0, 8'hA5, T};
    vecs[8]  = '{"rom_spur",   1'b0, 14'h1010, 8'h00,  2, 4'b1101, 5, 4'b0010, 1'b0, 8'hA5, 3};
    vecs[9]  = '{"ctl_rd_pc",  1'b0, 14'h0005, 8'h00,  0, 4'b0000, 0, 4'b0001, 1'b0, 8'h3C, 1};
    vecs[10] = '{"ctl_10",     1'b0, 14'h0010, 8'h00, -1, 4'b0000, 0, 4'b0000, 1'b1, 8'h00, 0};
    vecs[11] = '{"ram_wr",     1'b1, 14'h2FFF, 8'hE7,  4, 4'b0000, 2, 4'b0100, 1'b0, 8'h00, 5};

    rst = 1'b1; host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = '0;
    host_req_wdata = '0; host_rsp_ready = 1'b0; tgt_ack = 4'b0000; tgt_rdata = 32'hC35AA53C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", 32'(host_req_ready), 32'd0);
    chk("reset.rsp", {22'd0, host_rsp_valid, host_rsp_err, host_rsp_rdata}, 32'd0);
    chk("reset.tgt", {11'd0, tgt_req, tgt_write, tgt_addr, tgt_wdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_after", 32'(host_req_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Reset while a ROM request is outstanding; a late ack afterwards must be ignored.
    @(posedge clk); #1;
    host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 14'h1044;
    @(posedge clk); #1;
    host_req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.tgt_req", 32'(tgt_req), 32'b0010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.req_dropped", 32'(tgt_req), 32'd0);
    chk("rstmid.no_rsp", 32'(host_rsp_valid), 32'd0);
    chk("rstmid.ready_in_rst", 32'(host_req_ready), 32'd0);
    chk("rstmid.addr_cleared", 32'(tgt_addr), 32'd0);
    tgt_ack = 4'b0010;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.ready_after", 32'(host_req_ready), 32'd1);
    chk("rstmid.late_ack1", {27'd0, host_rsp_valid, tgt_req}, 32'd0);
    @(negedge clk);
    chk("rstmid.late_ack2", {27'd0, host_rsp_valid, tgt_req}, 32'd0);
    tgt_ack = 4'b0000;
    $display("[TB] txn reset_mid_issue done");
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
